// File: rtl/decode_stage.sv
// RV32I decode stage: register file with write-through bypass, immediate/control decode,
// load-use hazard detection and the D/E pipeline register. `define DECODE_MUL_EN enables M-extension multiply decode.
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_pc,
  input  logic [31:0] fd_instr,
  input  logic        dcache_stall,
  input  logic        icache_stall,
  input  logic        mul_stall,
  input  logic        br_en,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        load_stall,
  output logic [31:0] de_pc,
  output logic [31:0] de_rs1_data,
  output logic [31:0] de_rs2_data,
  output logic [31:0] de_imm,
  output logic [4:0]  de_rs1,
  output logic [4:0]  de_rs2,
  output logic [4:0]  de_rd,
  output logic [2:0]  de_funct3,
  output logic [3:0]  de_alu_op,
  output logic        de_alu_src,
  output logic        de_regwrite,
  output logic        de_memread,
  output logic        de_memwrite,
  output logic        de_branch,
  output logic        de_jal,
  output logic        de_jalr,
  output logic        de_mul,
  output logic        de_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_ADDPC = 4'd11
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        mul;
    logic        illegal;
  } de_t;

  function automatic de_t bubble();
    de_t b;
    b    = '0;
    b.pc = RESET_PC;
    return b;
  endfunction

  logic [31:0] regs [32];
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [6:0]  funct7;
  fmt_e        fmt;
  logic        use_rs1;
  logic        use_rs2;
  logic        hold;
  de_t         dec;
  de_t         de_q;

  assign rs1_idx = fd_instr[19:15];
  assign rs2_idx = fd_instr[24:20];
  assign funct7  = fd_instr[31:25];
  assign hold    = dcache_stall | icache_stall | mul_stall;

  // Register file; x0 is never written so it stays 0 from reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_val = '0;
    if (rs1_idx != 5'd0) rs1_val = (wb_en && wb_rd == rs1_idx) ? wb_data : regs[rs1_idx];
  end

  always_comb begin
    rs2_val = '0;
    if (rs2_idx != 5'd0) rs2_val = (wb_en && wb_rd == rs2_idx) ? wb_data : regs[rs2_idx];
  end

  always_comb begin
    dec = bubble();
    fmt = FMT_NONE;
    if (fd_instr != 32'd0) begin
      dec.pc       = fd_pc;
      dec.rs1      = rs1_idx;
      dec.rs2      = rs2_idx;
      dec.rd       = fd_instr[11:7];
      dec.funct3   = fd_instr[14:12];
      dec.rs1_data = rs1_val;
      dec.rs2_data = rs2_val;
      case (fd_instr[6:0])
        OPC_LUI: begin
          fmt = FMT_U; dec.regwrite = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_PASSB;
        end
        OPC_AUIPC: begin
          fmt = FMT_U; dec.regwrite = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADDPC;
        end
        OPC_JAL: begin
          fmt = FMT_J; dec.regwrite = 1'b1; dec.jal = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADDPC;
        end
        OPC_JALR: begin
          fmt = FMT_I; dec.regwrite = 1'b1; dec.jalr = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADDPC;
        end
        OPC_BRANCH: begin
          fmt = FMT_B; dec.branch = 1'b1; dec.alu_op = ALU_SUB;
        end
        OPC_LOAD: begin
          fmt = FMT_I; dec.regwrite = 1'b1; dec.memread = 1'b1; dec.alu_src = 1'b1;
        end
        OPC_STORE: begin
          fmt = FMT_S; dec.memwrite = 1'b1; dec.alu_src = 1'b1;
        end
        OPC_OPIMM, OPC_OP: begin
          fmt          = (fd_instr[6:0] == OPC_OP) ? FMT_R : FMT_I;
          dec.regwrite = 1'b1;
          dec.alu_src  = (fd_instr[6:0] == OPC_OPIMM);
          case (fd_instr[14:12])
            3'b000:  dec.alu_op = (fd_instr[6:0] == OPC_OP && fd_instr[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  dec.alu_op = ALU_SLL;
            3'b010:  dec.alu_op = ALU_SLT;
            3'b011:  dec.alu_op = ALU_SLTU;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = fd_instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
          if (fd_instr[6:0] == OPC_OP && funct7 == 7'b0000001) begin
            dec.alu_op = ALU_ADD;
`ifdef DECODE_MUL_EN
            dec.mul = 1'b1;
`else
            fmt          = FMT_NONE;
            dec.regwrite = 1'b0;
            dec.illegal  = 1'b1;
`endif
          end
        end
        default: dec.illegal = 1'b1;
      endcase

      case (fmt)
        FMT_I:   dec.imm = {{20{fd_instr[31]}}, fd_instr[31:20]};
        FMT_S:   dec.imm = {{20{fd_instr[31]}}, fd_instr[31:25], fd_instr[11:7]};
        FMT_B:   dec.imm = {{19{fd_instr[31]}}, fd_instr[31], fd_instr[7], fd_instr[30:25], fd_instr[11:8], 1'b0};
        FMT_U:   dec.imm = {fd_instr[31:12], 12'b0};
        FMT_J:   dec.imm = {{11{fd_instr[31]}}, fd_instr[31], fd_instr[19:12], fd_instr[20], fd_instr[30:21], 1'b0};
        default: dec.imm = '0;
      endcase
    end
  end

  assign use_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  assign use_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

  // Stall only when the instruction in execute is a load whose result the current one consumes.
  assign load_stall = !br_en && de_q.memread && (de_q.rd != 5'd0) &&
                      ((use_rs1 && de_q.rd == rs1_idx) || (use_rs2 && de_q.rd == rs2_idx));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      de_q <= bubble();
    end else if (!hold) begin
      if (br_en || load_stall) de_q <= bubble();
      else                     de_q <= dec;
    end
  end

  assign de_pc       = de_q.pc;
  assign de_rs1_data = de_q.rs1_data;
  assign de_rs2_data = de_q.rs2_data;
  assign de_imm      = de_q.imm;
  assign de_rs1      = de_q.rs1;
  assign de_rs2      = de_q.rs2;
  assign de_rd       = de_q.rd;
  assign de_funct3   = de_q.funct3;
  assign de_alu_op   = de_q.alu_op;
  assign de_alu_src  = de_q.alu_src;
  assign de_regwrite = de_q.regwrite;
  assign de_memread  = de_q.memread;
  assign de_memwrite = de_q.memwrite;
  assign de_branch   = de_q.branch;
  assign de_jal      = de_q.jal;
  assign de_jalr     = de_q.jalr;
  assign de_mul      = de_q.mul;
  assign de_illegal  = de_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: the stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the D/E outputs and load_stall.
module tb_decode_stage;

  localparam logic [7:0] F_RW   = 8'h80;
  localparam logic [7:0] F_MR   = 8'h40;
  localparam logic [7:0] F_MW   = 8'h20;
  localparam logic [7:0] F_BR   = 8'h10;
  localparam logic [7:0] F_JAL  = 8'h08;
  localparam logic [7:0] F_JALR = 8'h04;
  localparam logic [7:0] F_MUL  = 8'h02;
  localparam logic [7:0] F_ILL  = 8'h01;

  typedef struct {
    int          tag;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  op;
    logic        src;
    logic [7:0]  fl;
    logic        ls;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fd_pc = '0, fd_instr = '0, wb_data = '0;
  logic        dcache_stall = 1'b0, icache_stall = 1'b0, mul_stall = 1'b0, br_en = 1'b0, wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        load_stall;
  logic [31:0] de_pc, de_rs1_data, de_rs2_data, de_imm;
  logic [4:0]  de_rs1, de_rs2, de_rd;
  logic [2:0]  de_funct3;
  logic [3:0]  de_alu_op;
  logic        de_alu_src, de_regwrite, de_memread, de_memwrite, de_branch, de_jal, de_jalr, de_mul, de_illegal;

  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  exp_t q[$];
  exp_t mon_e;

  decode_stage #(.RESET_PC(32'h0000_1000)) dut (
    .clock(clock), .reset(reset), .fd_pc(fd_pc), .fd_instr(fd_instr),
    .dcache_stall(dcache_stall), .icache_stall(icache_stall), .mul_stall(mul_stall),
    .br_en(br_en), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_stall(load_stall), .de_pc(de_pc), .de_rs1_data(de_rs1_data), .de_rs2_data(de_rs2_data),
    .de_imm(de_imm), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd), .de_funct3(de_funct3),
    .de_alu_op(de_alu_op), .de_alu_src(de_alu_src), .de_regwrite(de_regwrite),
    .de_memread(de_memread), .de_memwrite(de_memwrite), .de_branch(de_branch),
    .de_jal(de_jal), .de_jalr(de_jalr), .de_mul(de_mul), .de_illegal(de_illegal)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] imm,
                              input logic [3:0] op, input logic src, input logic [7:0] fl,
                              input logic [31:0] rs1d, input logic [31:0] rs2d);
    exp_t e;
    e.tag = 0; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.f3 = f3; e.imm = imm;
    e.op = op; e.src = src; e.fl = fl; e.rs1d = rs1d; e.rs2d = rs2d; e.ls = 1'b0;
    return e;
  endfunction

  task automatic chk(input int tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got 0x%08h, expected 0x%08h", tag, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge and queue what the monitor must see before the next one.
  task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic ms, input logic ds,
                      input logic is, input logic br, input logic wen, input logic [4:0] wrd,
                      input logic [31:0] wd, input exp_t e, input logic ls);
    exp_t x;
    fd_pc = pc; fd_instr = instr; mul_stall = ms; dcache_stall = ds; icache_stall = is;
    br_en = br; wb_en = wen; wb_rd = wrd; wb_data = wd;
    x = e; x.ls = ls; x.tag = step_no;
    q.push_back(x);
    step_no++;
    @(posedge clock); #1;
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk(mon_e.tag, "load_stall", {31'd0, load_stall}, {31'd0, mon_e.ls});
      chk(mon_e.tag, "de_pc", de_pc, mon_e.pc);
      chk(mon_e.tag, "de_rs1_data", de_rs1_data, mon_e.rs1d);
      chk(mon_e.tag, "de_rs2_data", de_rs2_data, mon_e.rs2d);
      chk(mon_e.tag, "de_imm", de_imm, mon_e.imm);
      chk(mon_e.tag, "de_rs1", {27'd0, de_rs1}, {27'd0, mon_e.rs1});
      chk(mon_e.tag, "de_rs2", {27'd0, de_rs2}, {27'd0, mon_e.rs2});
      chk(mon_e.tag, "de_rd", {27'd0, de_rd}, {27'd0, mon_e.rd});
      chk(mon_e.tag, "de_funct3", {29'd0, de_funct3}, {29'd0, mon_e.f3});
      chk(mon_e.tag, "de_alu_op", {28'd0, de_alu_op}, {28'd0, mon_e.op});
      chk(mon_e.tag, "de_alu_src", {31'd0, de_alu_src}, {31'd0, mon_e.src});
      chk(mon_e.tag, "de_flags",
          {24'd0, de_regwrite, de_memread, de_memwrite, de_branch, de_jal, de_jalr, de_mul, de_illegal},
          {24'd0, mon_e.fl});
    end
  end

  initial begin
    exp_t B, E1, E2, E4, E5, E6, E7, E9, E12, E13, E16, E17, E19, E20, E21, E22, E23, E24, E25, E26, E29;
    B   = mk(32'h1000, 0, 0, 0, 0, 32'h0, 0, 0, 8'h00, 32'h0, 32'h0);
    E1  = mk(32'h100, 0, 5, 1, 0, 32'h5, 0, 1, F_RW, 32'h0, 32'h0);
    E2  = mk(32'h104, 1, 0, 2, 2, 32'h0, 0, 1, F_RW | F_MR, 32'h64, 32'h0);
    E4  = mk(32'h108, 2, 2, 3, 0, 32'h0, 0, 0, F_RW, 32'h300, 32'h300);
    E5  = mk(32'h10C, 5, 31, 6, 0, 32'hFFFF_FFFF, 0, 1, F_RW, 32'hDEAD_BEEF, 32'h0);
    E6  = mk(32'h110, 0, 5, 7, 0, 32'h0, 0, 0, F_RW, 32'h0, 32'hDEAD_BEEF);
    E7  = mk(32'h114, 0, 0, 8, 0, 32'h0, 0, 0, F_RW, 32'h0, 32'h0);
    E9  = mk(32'h118, 8, 3, 9, 5, 32'h1234_5000, 10, 1, F_RW, 32'h0, 32'h0);
    E12 = mk(32'h11C, 0, 5, 7, 0, 32'h0, 0, 0, F_RW, 32'h0, 32'hDEAD_BEEF);
    E13 = mk(32'h120, 1, 0, 2, 2, 32'h0, 0, 1, F_RW | F_MR, 32'h64, 32'h0);
    E16 = mk(32'h124, 2, 2, 3, 0, 32'h0, 0, 0, F_RW, 32'h300, 32'h300);
    E17 = mk(32'h128, 1, 0, 2, 2, 32'h0, 0, 1, F_RW | F_MR, 32'h64, 32'h0);
    E19 = mk(32'h130, 1, 2, 4, 2, 32'h4, 0, 1, F_MW, 32'h64, 32'h300);
    E20 = mk(32'h134, 1, 2, 25, 0, 32'hFFFF_FFF8, 1, 0, F_BR, 32'h64, 32'h300);
    E21 = mk(32'h138, 0, 16, 1, 0, 32'h10, 11, 1, F_RW | F_JAL, 32'h0, 32'h0);
    E22 = mk(32'h13C, 31, 31, 31, 7, 32'h0, 0, 0, F_ILL, 32'h0, 32'h0);
`ifdef DECODE_MUL_EN
    E23 = mk(32'h140, 1, 2, 1, 0, 32'h0, 0, 0, F_RW | F_MUL, 32'h64, 32'h300);
`else
    E23 = mk(32'h140, 1, 2, 1, 0, 32'h0, 0, 0, F_ILL, 32'h64, 32'h300);
`endif
    E24 = mk(32'h144, 1, 0, 5, 2, 32'h0, 0, 1, F_RW | F_MR, 32'h64, 32'h0);
    E25 = mk(32'h148, 0, 5, 6, 0, 32'h5, 0, 1, F_RW, 32'h0, 32'hDEAD_BEEF);
    E26 = mk(32'h14C, 1, 0, 2, 2, 32'h0, 0, 1, F_RW | F_MR, 32'h64, 32'h0);
    E29 = mk(32'h150, 2, 2, 3, 0, 32'h0, 0, 0, F_RW, 32'h0, 32'h0);

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    //    pc        instr          ms  ds  is  br  wen rd  wdata           expect ls
    step(32'h000, 32'h0000_0000, 0, 0, 0, 0, 1, 1, 32'h64,        B,   0);  // reset state, x1=100
    step(32'h100, 32'h0050_0093, 0, 0, 0, 0, 1, 2, 32'h200,       B,   0);  // addi x1,x0,5
    step(32'h104, 32'h0000_A103, 0, 0, 0, 0, 0, 0, 32'h0,         E1,  0);  // lw x2,0(x1)
    step(32'h108, 32'h0021_01B3, 0, 0, 0, 0, 0, 0, 32'h0,         E2,  1);  // add x3,x2,x2 -> stall
    step(32'h108, 32'h0021_01B3, 0, 0, 0, 0, 1, 2, 32'h300,       B,   0);  // re-decode, bypass x2
    step(32'h10C, 32'hFFF2_8313, 0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, E4,  0);  // addi x6,x5,-1 bypass
    step(32'h110, 32'h0050_03B3, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, E5,  0);  // add x7,x0,x5; write x0
    step(32'h114, 32'h0000_0433, 0, 0, 0, 0, 0, 0, 32'h0,         E6,  0);  // add x8,x0,x0
    step(32'h118, 32'h1234_54B7, 0, 0, 0, 1, 0, 0, 32'h0,         E7,  0);  // lui flushed
    step(32'h118, 32'h1234_54B7, 0, 0, 0, 0, 0, 0, 32'h0,         B,   0);  // lui x9
    step(32'h11C, 32'h0050_03B3, 1, 0, 0, 1, 0, 0, 32'h0,         E9,  0);  // mul_stall beats br_en
    step(32'h11C, 32'h0050_03B3, 0, 0, 1, 1, 0, 0, 32'h0,         E9,  0);  // icache_stall beats br_en
    step(32'h11C, 32'h0050_03B3, 0, 0, 0, 0, 0, 0, 32'h0,         E9,  0);
    step(32'h120, 32'h0000_A103, 0, 0, 0, 0, 0, 0, 32'h0,         E12, 0);  // lw x2
    step(32'h124, 32'h0021_01B3, 0, 1, 0, 0, 0, 0, 32'h0,         E13, 1);  // stall persists under hold
    step(32'h124, 32'h0021_01B3, 0, 0, 0, 0, 0, 0, 32'h0,         E13, 1);
    step(32'h124, 32'h0021_01B3, 0, 0, 0, 0, 0, 0, 32'h0,         B,   0);
    step(32'h128, 32'h0000_A103, 0, 0, 0, 0, 0, 0, 32'h0,         E16, 0);  // lw x2
    step(32'h12C, 32'h0021_01B3, 0, 0, 0, 1, 0, 0, 32'h0,         E17, 0);  // br_en masks stall
    step(32'h130, 32'h0020_A223, 0, 0, 0, 0, 0, 0, 32'h0,         B,   0);  // sw x2,4(x1)
    step(32'h134, 32'hFE20_8CE3, 0, 0, 0, 0, 0, 0, 32'h0,         E19, 0);  // beq x1,x2,-8
    step(32'h138, 32'h0100_00EF, 0, 0, 0, 0, 0, 0, 32'h0,         E20, 0);  // jal x1,16
    step(32'h13C, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 32'h0,         E21, 0);  // illegal opcode
    step(32'h140, 32'h0220_80B3, 0, 0, 0, 0, 0, 0, 32'h0,         E22, 0);  // mul x1,x1,x2
    step(32'h144, 32'h0000_A283, 0, 0, 0, 0, 0, 0, 32'h0,         E23, 0);  // lw x5
    step(32'h148, 32'h0050_0313, 0, 0, 0, 0, 0, 0, 32'h0,         E24, 0);  // rs2 field==5 unused
    step(32'h14C, 32'h0000_A103, 0, 0, 0, 0, 0, 0, 32'h0,         E25, 0);  // lw x2
    step(32'h150, 32'h0021_01B3, 1, 0, 0, 0, 0, 0, 32'h0,         E26, 1);  // hold with stall
    reset = 1'b0;                                                            // async reset mid-hold
    step(32'h150, 32'h0021_01B3, 1, 0, 0, 0, 0, 0, 32'h0,         B,   0);
    reset = 1'b1;
    step(32'h150, 32'h0021_01B3, 0, 0, 0, 0, 0, 0, 32'h0,         B,   0);  // regfile cleared
    step(32'h000, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0,         E29, 0);
    step(32'h000, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0,         B,   0);

    @(negedge clock); #1;
    chk(step_no, "queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
